st_buffer_stage: RTL
====================

# st_buffer_stage

Store-side counterpart of the write-back load aligner. It accepts store commands from the MA stage, checks alignment, and replicates store data into byte lanes with a 4-bit byte enable. Accepted stores are queued in a small in-order write buffer that drains to data memory through a request/acknowledge handshake. It also flags loads that hit a pending store and reports buffer-full and buffer-empty status to the pipeline.

## Interface
- DEPTH, 4, write-buffer entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_st_ma  in  1  store command valid in MA
- st_code_ma  in  2  size (funct3[1:0]): 00 byte, 01 half, 10 word, 11 reserved
- st_adr_ma  in  32  byte address
- st_data_ma  in  32  store data (low bits significant)
- cmd_ld_ma  in  1  load in MA (hazard check)
- ld_adr_ma  in  32  load byte address
- stall  in  1  pipeline stall; no push while high
- rst_pipe  in  1  pipeline flush; blocks push this cycle and does not purge buffer
- dmem_we  out  1  write request, head entry valid
- dmem_adr  out  30  word address of head
- dmem_wdata  out  32  lane-replicated data of head
- dmem_be  out  4  byte enables of head
- dmem_ack  in  1  memory accepted head this cycle
- st_full  out  1  buffer full; pipeline must stall stores
- st_empty  out  1  buffer empty (fence/drain status)
- ld_hit  out  1  load word address matches any valid entry
- st_misalign  out  1  one-cycle pulse: misaligned/reserved store dropped

## Operation
- Push condition: cmd_st_ma & ~stall & ~rst_pipe & ~st_full & aligned & st_code_ma!=11.
- Alignment: half requires adr[0]=0; word requires adr[1:0]=0; byte always aligned.
- Lane build: byte, wdata={4{data[7:0]}}, be=4'b0001<<adr[1:0]; half, wdata={2{data[15:0]}}, be=adr[1]?4'b1100:4'b0011; word, wdata=data, be=4'b1111.
- Entry stores {adr[31:2], wdata, be}; FIFO with wr/rd pointers of log2(DEPTH)+1 bits; full when pointers differ only in MSB, empty when equal.
- Drain: dmem_we=~st_empty; outputs driven from head entry; pop on dmem_we & dmem_ack. Strict in-order; no merging.
- Simultaneous push and pop: both occur and count is unchanged. Full blocks push even if pop is occurring in the same cycle; the push retries next cycle.
- ld_hit: combinational; cmd_ld_ma & OR over valid entries of (entry.adr == ld_adr_ma[31:2]); 0 when empty. Entry popped this cycle still counts.
- Misalign/reserved with cmd_st_ma & ~stall & ~rst_pipe: nothing pushed; st_misalign registered high next cycle for exactly one cycle.
- Flush (rst_pipe) does not discard queued entries, because they are committed stores.

## Timing
- Reset (rst high at clk edge): pointers=0, st_empty=1, st_full=0, dmem_we=0, dmem_adr=0, dmem_wdata=0, dmem_be=0, st_misalign=0, ld_hit=0. Reset mid-drain discards all entries, and dmem_we drops the next cycle.
- Push to dmem_we: 1 cycle (entry written at edge N, dmem_we high after edge N).
- dmem_we/adr/wdata/be hold stable until the ack'd edge. Next entry appears the cycle after ack; back-to-back acks give one store per cycle.
- st_full, st_empty: registered-state decodes, valid the cycle after the changing edge.
- st_misalign: 1-cycle latency after offending command.

## Test plan
- sb to 0x1003, data 0x000000A5 -> dmem_adr=0x400, wdata=0xA5A5A5A5, be=1000, dmem_we 1 cycle after push; ack pops it and st_empty=1.
- sh to 0x2002, data 0x1234 -> wdata=0x12341234, be=1100. sh to 0x2001 -> no push, st_misalign pulse 1 cycle, st_empty stays 1.
- 4 sw with ack held low -> st_full=1, a 5th store is not pushed. Ack asserted the same cycle as the 5th store -> pop only; 5th pushed next cycle and order is preserved.
- sw to 0x100 pending, lw from 0x102 -> ld_hit=1; lw from 0x104 -> ld_hit=0; after ack -> ld_hit=0.
- Continuous ack with a store every cycle -> throughput 1/cycle, count steady at 1, no full.
- rst asserted with 3 entries queued -> next cycle dmem_we=0, st_empty=1, all outputs at reset values. rst_pipe with a store in MA -> not pushed, and queued entries are kept.

Source files
------------

// File: rtl/st_buffer_stage.sv
// Store buffer stage: aligns MA-stage stores into byte lanes and queues them in an
// in-order write buffer that drains to data memory; also flags loads hitting pending stores.
module st_buffer_stage #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_st_ma,
  input  logic [1:0]  st_code_ma,
  input  logic [31:0] st_adr_ma,
  input  logic [31:0] st_data_ma,
  input  logic        cmd_ld_ma,
  input  logic [31:0] ld_adr_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  output logic        dmem_we,
  output logic [29:0] dmem_adr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  output logic        st_full,
  output logic        st_empty,
  output logic        ld_hit,
  output logic        st_misalign
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic [29:0]   adr_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];
  logic [AW-1:0] head;
  logic [31:0]   lane_data;
  logic [3:0]    lane_be;
  logic          aligned, attempt, push, pop, misalign_q;
  logic          hit;
  logic [AW-1:0] idx;
  logic          unused_ld_offset;

  // Lane build; the reserved size code is treated as never aligned.
  always_comb begin
    lane_data = st_data_ma;
    lane_be   = 4'b1111;
    aligned   = 1'b1;
    case (st_code_ma)
      2'b00: begin
        lane_data = {4{st_data_ma[7:0]}};
        lane_be   = 4'b0001 << st_adr_ma[1:0];
      end
      2'b01: begin
        lane_data = {2{st_data_ma[15:0]}};
        lane_be   = st_adr_ma[1] ? 4'b1100 : 4'b0011;
        aligned   = ~st_adr_ma[0];
      end
      2'b10:   aligned = (st_adr_ma[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign attempt  = cmd_st_ma & ~stall & ~rst_pipe;
  assign push     = attempt & aligned & ~st_full;
  assign st_empty = (wr_ptr == rd_ptr);
  assign st_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign head     = rd_ptr[AW-1:0];

  // Memory handshake: dmem_we requests a write of the head entry and the payload
  // stays constant until an edge where dmem_ack is sampled high, which pops it.
  assign pop        = dmem_we & dmem_ack;
  assign dmem_we    = ~st_empty;
  assign dmem_adr   = st_empty ? 30'd0 : adr_mem[head];
  assign dmem_wdata = st_empty ? 32'd0 : data_mem[head];
  assign dmem_be    = st_empty ? 4'd0  : be_mem[head];
  assign st_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      misalign_q <= attempt & ~aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_ptr[AW-1:0]]  <= st_adr_ma[31:2];
      data_mem[wr_ptr[AW-1:0]] <= lane_data;
      be_mem[wr_ptr[AW-1:0]]   <= lane_be;
    end
  end

  // Walk the occupied slots from the head; the entry being popped this cycle still counts.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (((AW+1)'(k) < count) && (adr_mem[idx] == ld_adr_ma[31:2])) hit = 1'b1;
    end
  end

  assign ld_hit = cmd_ld_ma & hit;
  assign unused_ld_offset = ^ld_adr_ma[1:0];
endmodule
